load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter AW, default 8, giving the word-address width of the attached data memory.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit, CPU request present.
REQ-005 The block SHALL have port req_ready, output, 1 bit, block can accept a request.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 The block SHALL have port req_signed, input, 1 bit: load sign-extend when 1, zero-extend when 0.
REQ-009 The block SHALL have port req_addr, input, AW+2 bits, byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits, store data, right-aligned.
REQ-011 The block SHALL have port resp_valid, output, 1 bit, one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata, output, 32 bits, extended load result.
REQ-013 The block SHALL have port resp_err, output, 1 bit, misaligned or illegal-size request.
REQ-014 The block SHALL have port mem_we, output, 1 bit, memory write enable.
REQ-015 The block SHALL have port mem_a, output, AW bits, memory word address.
REQ-016 The block SHALL have port mem_wd, output, 32 bits, memory write data.
REQ-017 The block SHALL have port mem_rd, input, 32 bits, memory read data, combinational from mem_a.

Function
REQ-018 The FSM SHALL have states IDLE, RD, WR, RESP and ERR; req_ready SHALL be 1 only in IDLE.
REQ-019 When req_valid and req_ready are both high at an edge, the block SHALL latch we, size, signed, addr and wdata; req_valid outside IDLE SHALL be ignored.
REQ-020 Requests SHALL be misaligned when size=01 with addr[0]=1, when size=10 with addr[1:0]!=0, or when size=11; a misaligned request SHALL go IDLE->ERR.
REQ-021 An aligned request SHALL transition as follows: loads and byte/half stores go IDLE->RD; word stores go IDLE->WR.
REQ-022 In RD, mem_a SHALL equal latched addr[AW+1:2] and mem_we SHALL be 0; mem_rd SHALL be captured into a read buffer at the edge. RD SHALL then go to RESP for loads and to WR for stores.
REQ-023 In WR, mem_we SHALL be 1 and mem_a SHALL equal the latched word address. mem_wd SHALL equal wdata for a word store. For a byte/half store, mem_wd SHALL be the read buffer with only the addressed lanes replaced. WR SHALL then go to RESP.
REQ-024 Lanes SHALL be little-endian: byte n occupies bits [8n+7:8n], and a half at addr[1]=h occupies bits [16h+15:16h].
REQ-025 In RESP, resp_valid SHALL be 1 and resp_err 0. For loads, resp_rdata SHALL be the addressed lane extended per signed; for stores it SHALL be 0. RESP SHALL then go to IDLE.
REQ-026 In ERR, resp_valid SHALL be 1, resp_err 1 and resp_rdata 0, and no memory access SHALL occur; ERR SHALL then go to IDLE.
REQ-027 With the request accepted at edge k, resp_valid SHALL be high in the cycle after edge k+2 for loads and word stores, after edge k+3 for byte/half stores, and after edge k+1 for errors.
REQ-028 mem_we SHALL be 1 only in WR, exactly one cycle per store, and never for loads or errors.
REQ-029 All outputs SHALL be derived from registered state only, with no combinational path from req_* to mem_* or resp_*.
REQ-030 There SHALL be no response backpressure; a new request SHALL be acceptable in the first IDLE cycle after RESP/ERR.

Reset
REQ-031 While rst=1 at an edge, the block SHALL enter IDLE, and resp_valid, resp_err, resp_rdata, mem_wd and mem_a SHALL be 0.
REQ-032 mem_we SHALL be gated by rst, so that a reset asserted while in WR performs no write; any in-flight request SHALL be dropped with no response.

Verification
REQ-033 Word-store 0x8899AABB to addr 0x014, then byte load, signed, from addr 0x015 -> resp_rdata=0xFFFFFFAA at k+2; the same load unsigned -> 0x000000AA.
REQ-034 Half-store 0x1234 to addr 0x016 over word 0x8899AABB -> mem_we one cycle with mem_wd=0x1234AABB, resp_valid at k+3; a word load from 0x014 -> 0x1234AABB.
REQ-035 Word load from addr 0x013 -> resp_valid=1 and resp_err=1 at k+1, mem_we never asserted, resp_rdata=0.
REQ-036 rst asserted for one cycle while in WR of a store to word 5 -> mem_we=0, word 5 unchanged, no resp_valid, req_ready=1 next cycle.
REQ-037 req_valid held high for two back-to-back word loads -> second request accepted only in IDLE after first RESP; req_ready=0 in RD/RESP, two resp_valid pulses.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a single-ported word memory.
// Handles byte/half/word accesses, sign/zero extension and read-modify-write sub-word stores.
module load_store_unit #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW+1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StResp, StErr} state_e;

  state_e        state_q;
  logic          we_q;
  logic          sgn_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rbuf_q;

  logic          misaligned;
  logic [4:0]    lane_shift;
  logic [31:0]   lane;
  logic [31:0]   lane_mask;
  logic [31:0]   ins_data;
  logic [31:0]   load_val;
  logic [31:0]   store_val;

  always_comb begin
    misaligned = (req_size == 2'b11) ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            sgn_q   <= req_signed;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (misaligned) begin
              state_q <= StErr;
            end else if (req_we && req_size == 2'b10) begin
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          rbuf_q  <= mem_rd;
          state_q <= we_q ? StWr : StResp;
        end
        StWr:           state_q <= StResp;
        StResp, StErr:  state_q <= StIdle;
        default:        state_q <= StIdle;
      endcase
    end
  end

  // Aligned half accesses have addr[0]=0, so one shift serves both byte and half lanes.
  always_comb begin
    lane_shift = {addr_q[1:0], 3'b000};
    lane       = rbuf_q >> lane_shift;
    load_val   = rbuf_q;
    lane_mask  = '1;
    ins_data   = wdata_q;
    case (size_q)
      2'b00: begin
        load_val  = {{24{sgn_q & lane[7]}}, lane[7:0]};
        lane_mask = 32'h0000_00ff << lane_shift;
        ins_data  = {24'b0, wdata_q[7:0]} << lane_shift;
      end
      2'b01: begin
        load_val  = {{16{sgn_q & lane[15]}}, lane[15:0]};
        lane_mask = 32'h0000_ffff << lane_shift;
        ins_data  = {16'b0, wdata_q[15:0]} << lane_shift;
      end
      default: ;
    endcase
    store_val = (rbuf_q & ~lane_mask) | (ins_data & lane_mask);
  end

  assign req_ready  = (state_q == StIdle);
  assign mem_we     = (state_q == StWr) && !rst;
  assign mem_a      = addr_q[AW+1:2];
  assign mem_wd     = (state_q == StWr) ? store_val : 32'h0;
  assign resp_valid = (state_q == StResp) || (state_q == StErr);
  assign resp_err   = (state_q == StErr);
  assign resp_rdata = (state_q == StResp && !we_q) ? load_val : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a reference memory predicts each response,
// its latency, store write data and write count.
module tb_load_store_unit;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  load_store_unit #(.AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic        mem_init = 1'b1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h9e37_79b9 * (i + 1);
    end else if (mem_we) begin
      mem[mem_a] <= mem_wd;
    end
  end
  assign mem_rd = mem[mem_a];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] k;
    logic [31:0] lat;
    logic [31:0] nwe;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  bit   chk_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !mem_init) begin
      if (mem_we) begin
        we_cnt++;
        if (sb.size() != 0) check_eq("mem_wd", mem_wd, sb[0].wd);
        else check_eq("stray_we", {31'b0, mem_we}, 32'h0);
      end
      if (chk_ready) check_eq("req_ready", {31'b0, req_ready}, {31'b0, sb.size() == 0});
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check_eq("stray_resp", {31'b0, resp_valid}, 32'h0);
        end else begin
          e = sb.pop_front();
          check_eq("resp_rdata", resp_rdata, e.rdata);
          check_eq("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          check_eq("latency", cyc - e.k + 1, e.lat);
          check_eq("we_count", we_cnt, e.nwe);
          we_cnt = 0;
        end
      end
    end
  end

  // Leaves req_valid high after acceptance; the following request or drain overrides it.
  task automatic issue(input bit we, input logic [1:0] sz, input bit sg,
                       input logic [AW+1:0] a, input logic [31:0] wd);
    exp_t        e;
    int          waitc;
    int          wi;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      check_eq("accept_timeout", {31'b0, req_ready}, 32'h1);
      return;
    end
    e = '0;
    e.k = cyc + 1;
    if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) begin
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      wi = int'(a[AW+1:2]);
      w  = ref_mem[wi];
      if (we) begin
        case (sz)
          2'b00:   begin w[8*a[1:0] +: 8] = wd[7:0];   e.lat = 3; end
          2'b01:   begin w[16*a[1] +: 16] = wd[15:0];  e.lat = 3; end
          default: begin w = wd;                       e.lat = 2; end
        endcase
        ref_mem[wi] = w;
        e.nwe = 1;
        e.wd  = w;
      end else begin
        e.lat = 2;
        b = w[8*a[1:0] +: 8];
        h = w[16*a[1] +: 16];
        case (sz)
          2'b00:   e.rdata = sg ? {{24{b[7]}}, b} : {24'b0, b};
          2'b01:   e.rdata = sg ? {{16{h[15]}}, h} : {16'b0, h};
          default: e.rdata = w;
        endcase
      end
    end
    @(posedge clk);
    sb.push_back(e);
  endtask

  task automatic drain;
    int waitc;
    @(negedge clk);
    req_valid = 1'b0;
    waitc = 0;
    while (sb.size() != 0 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check_eq("drain_empty", sb.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'h9e37_79b9 * (i + 1);
    repeat (3) @(negedge clk);
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check_eq("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    check_eq("rst_mem_wd", mem_wd, 32'h0);
    check_eq("rst_mem_a", {24'b0, mem_a}, 32'h0);
    check_eq("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check_eq("rst_req_ready", {31'b0, req_ready}, 32'h1);
    rst = 1'b0;
    mem_init = 1'b0;
    chk_ready = 1'b1;

    // Directed: word store, byte loads, half store RMW, word load, misaligned error.
    issue(1'b1, 2'b10, 1'b0, 10'h014, 32'h8899_aabb);
    issue(1'b0, 2'b00, 1'b1, 10'h015, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 10'h015, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 10'h016, 32'h0000_1234);
    issue(1'b0, 2'b10, 1'b0, 10'h014, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 10'h013, 32'h0);
    drain();

    // Reset during WR of a word store to word 5 drops it with no write and no response.
    chk_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 10'h014;
    req_wdata = 32'hdead_beef;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("we_during_rst", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", {31'b0, req_ready}, 32'h1);
    check_eq("no_resp_after_rst", {31'b0, resp_valid}, 32'h0);
    check_eq("word5_intact", mem[5], ref_mem[5]);
    we_cnt = 0;
    chk_ready = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 10'h014, 32'h0);

    // Back-to-back loads with req_valid held high throughout.
    issue(1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 10'h024, 32'h0);
    drain();

    for (int n = 0; n < 80; n++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            10'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
